// File: rtl/common_pseudo_lru_pick_binw_pkg.sv
// Shared constants and helpers for the tree pseudo-LRU picker.
//
// The subject count and node count are derived from the log2 subject count
// here so every user of the tree agrees on the same sizing. The steer enum
// names the meaning of a node bit: 0 steers the pick into the lower-index
// half, 1 into the upper-index half.
package common_pseudo_lru_pick_binw_pkg;

    // Largest supported tree (32 subjects).
    localparam int LRU_MAX_SUBJECT_COUNT_LOG2 = 5;

    typedef enum logic {
        STEER_LOWER = 1'b0,
        STEER_UPPER = 1'b1
    } lru_steer_e;

    // Number of subjects N for a given log2 subject count.
    function automatic int lru_subject_count(input int count_log2);
        return 1 << count_log2;
    endfunction

    // Number of internal tree nodes (N-1) for a given log2 subject count.
    function automatic int lru_node_count(input int count_log2);
        return (1 << count_log2) - 1;
    endfunction

endpackage

// File: rtl/macro_decoder_bin_onehot.sv
// Binary to one-hot decoder.
//
// Ports:
//   bin    - binary index, WIDTH_LOG2 bits
//   onehot - one-hot output, 2**WIDTH_LOG2 bits, bit[bin] set
module macro_decoder_bin_onehot
    import common_pseudo_lru_pick_binw_pkg::*;
#(
    parameter int WIDTH_LOG2 = 1
) (
    input  logic [WIDTH_LOG2-1:0]                    bin,
    output logic [lru_subject_count(WIDTH_LOG2)-1:0] onehot
);

    localparam int WIDTH = lru_subject_count(WIDTH_LOG2);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign onehot[gi] = (bin == WIDTH_LOG2'(gi));
        end
    endgenerate

endmodule

// File: rtl/common_pseudo_lru_pick_binw.sv
// Tree pseudo-LRU picker with binary-encoded touch port.
//
// The state is N-1 node bits in heap order (root = node 0, node i has
// children 2i+1 for the lower-index half and 2i+2 for the upper-index half).
// The pick walks from the root following each node's steer bit, falling back
// to the other child when the steered subtree has no eligible subject.
// Touching a subject points every node on its path away from it.
//
// Ports:
//   clk    - clock, all state updates on rising edge
//   reset  - synchronous active-high reset, clears all node bits
//   waddr  - binary subject index to touch when wen is high
//   wen    - touch strobe for waddr
//   alloc  - consume the current pick (touch qaddr) when qvalid is high
//   dvalid - per-subject eligibility mask for picking
//   qaddr  - one-hot picked subject, all-zero when nothing is eligible
//   qvalid - high when qaddr holds a pick
//
// SUBJECT_COUNT_LOG2 is legal in the range 1..LRU_MAX_SUBJECT_COUNT_LOG2.
module common_pseudo_lru_pick_binw
    import common_pseudo_lru_pick_binw_pkg::*;
#(
    parameter int SUBJECT_COUNT_LOG2 = 1
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic [SUBJECT_COUNT_LOG2-1:0]                   waddr,
    input  logic                                            wen,
    input  logic                                            alloc,
    input  logic [lru_subject_count(SUBJECT_COUNT_LOG2)-1:0] dvalid,
    output logic [lru_subject_count(SUBJECT_COUNT_LOG2)-1:0] qaddr,
    output logic                                            qvalid
);

    localparam int N     = lru_subject_count(SUBJECT_COUNT_LOG2);
    localparam int NODES = lru_node_count(SUBJECT_COUNT_LOG2);
    localparam int L     = SUBJECT_COUNT_LOG2;

    logic [NODES-1:0] node_reg;
    logic [NODES-1:0] node_next;
    logic [NODES-1:0] go_upper;     // effective direction taken at each node
    logic [N-1:0]     wen_onehot;
    logic [N-1:0]     wen_vec;
    logic [N-1:0]     alloc_vec;
    logic             any_eligible;

    macro_decoder_bin_onehot #(
        .WIDTH_LOG2 (SUBJECT_COUNT_LOG2)
    ) u_waddr_decoder (
        .bin    (waddr),
        .onehot (wen_onehot)
    );

    assign any_eligible = |dvalid;
    assign wen_vec      = wen ? wen_onehot : '0;
    // qaddr is all-zero without a valid pick, so an unqualified alloc touches nothing.
    assign alloc_vec    = (alloc && qvalid) ? qaddr : '0;

    // Per-node logic: gd is tree depth, gk the position within that depth.
    // A node at depth gd covers N>>gd consecutive subjects starting at LO.
    generate
        for (genvar gd = 0; gd < L; gd++) begin : g_level
            for (genvar gk = 0; gk < (1 << gd); gk++) begin : g_node
                localparam int IDX  = (1 << gd) - 1 + gk;
                localparam int HALF = N >> (gd + 1);
                localparam int LO   = gk * (N >> gd);
                localparam int HI   = LO + HALF;

                logic lower_any;
                logic upper_any;
                logic wen_hit;
                logic wen_low;
                logic alloc_hit;
                logic alloc_low;
                lru_steer_e wen_steer;
                lru_steer_e alloc_steer;

                assign lower_any = |dvalid[LO +: HALF];
                assign upper_any = |dvalid[HI +: HALF];

                // Follow the steer bit unless that side is empty. When both
                // sides are empty the node is never on the active path.
                assign go_upper[IDX] = (node_reg[IDX] == STEER_UPPER) ? upper_any : !lower_any;

                assign wen_hit   = |wen_vec[LO +: 2*HALF];
                assign wen_low   = |wen_vec[LO +: HALF];
                assign alloc_hit = |alloc_vec[LO +: 2*HALF];
                assign alloc_low = |alloc_vec[LO +: HALF];

                // Point away from the touched subject.
                assign wen_steer   = wen_low   ? STEER_UPPER : STEER_LOWER;
                assign alloc_steer = alloc_low ? STEER_UPPER : STEER_LOWER;

                // The wen touch lands after the alloc touch, so it wins on
                // shared path nodes.
                assign node_next[IDX] = wen_hit   ? wen_steer :
                                        alloc_hit ? alloc_steer :
                                                    node_reg[IDX];
            end
        end
    endgenerate

    // A subject is picked when every ancestor's effective direction leads to
    // it. Ancestor at depth gd is selected by the top gd bits of the index;
    // the branch taken there is bit (L-1-gd).
    generate
        for (genvar gs = 0; gs < N; gs++) begin : g_subject
            logic [L-1:0] step_ok;
            for (genvar gd = 0; gd < L; gd++) begin : g_step
                localparam int ANC = (1 << gd) - 1 + (gs >> (L - gd));
                localparam bit DIR = ((gs >> (L - 1 - gd)) % 2) == 1;
                assign step_ok[gd] = DIR ? go_upper[ANC] : !go_upper[ANC];
            end
            assign qaddr[gs] = any_eligible & (&step_ok);
        end
    endgenerate

    assign qvalid = |qaddr;

    always_ff @(posedge clk) begin
        if (reset) begin
            node_reg <= '0;
        end else begin
            node_reg <= node_next;
        end
    end

endmodule

// File: tb/tb_common_pseudo_lru_pick_binw.sv
module tb_common_pseudo_lru_pick_binw;

    localparam int L     = 2;
    localparam int N     = 1 << L;
    localparam int NODES = N - 1;

    logic           clk = 1'b0;
    logic           reset;
    logic [L-1:0]   waddr;
    logic           wen;
    logic           alloc;
    logic [N-1:0]   dvalid;
    logic [N-1:0]   qaddr;
    logic           qvalid;

    int err_count = 0;
    int chk_count = 0;

    // Reference state: one steer bit per tree node, heap order.
    logic [NODES-1:0] m_state = '0;

    always #5 clk = ~clk;

    common_pseudo_lru_pick_binw #(
        .SUBJECT_COUNT_LOG2 (L)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .waddr  (waddr),
        .wen    (wen),
        .alloc  (alloc),
        .dvalid (dvalid),
        .qaddr  (qaddr),
        .qvalid (qvalid)
    );

    // Walk the tree by subject ranges, choosing a half at each level.
    function automatic logic [N-1:0] m_pick(input logic [NODES-1:0] st, input logic [N-1:0] dv);
        int idx;
        int lo;
        int size;
        int half;
        bit lower_any;
        bit upper_any;
        bit go_up;
        logic [N-1:0] r;
        r = '0;
        if (dv == '0) return r;
        idx = 0;
        lo = 0;
        size = N;
        while (size > 1) begin
            half = size / 2;
            lower_any = 0;
            upper_any = 0;
            for (int k = 0; k < half; k++) begin
                lower_any |= dv[lo + k];
                upper_any |= dv[lo + half + k];
            end
            go_up = st[idx] ? upper_any : !lower_any;
            if (go_up) begin
                lo  = lo + half;
                idx = 2 * idx + 2;
            end else begin
                idx = 2 * idx + 1;
            end
            size = half;
        end
        r[lo] = 1'b1;
        return r;
    endfunction

    // Point each node on the subject's path away from it.
    function automatic logic [NODES-1:0] m_touch(input logic [NODES-1:0] st, input int s);
        int idx;
        int lo;
        int size;
        int half;
        logic [NODES-1:0] r;
        r = st;
        idx = 0;
        lo = 0;
        size = N;
        while (size > 1) begin
            half = size / 2;
            if (s < lo + half) begin
                r[idx] = 1'b1;
                idx = 2 * idx + 1;
            end else begin
                r[idx] = 1'b0;
                lo = lo + half;
                idx = 2 * idx + 2;
            end
            size = half;
        end
        return r;
    endfunction

    // Advance the model with the current inputs, then clock the DUT.
    task automatic tick();
        logic [N-1:0] pick;
        if (reset) begin
            m_state = '0;
        end else begin
            pick = m_pick(m_state, dvalid);
            if (alloc && pick != '0) begin
                for (int s = 0; s < N; s++) begin
                    if (pick[s]) m_state = m_touch(m_state, s);
                end
            end
            if (wen) m_state = m_touch(m_state, int'(waddr));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0;
        wen   = 1'b0;
        alloc = 1'b0;
        waddr = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        dvalid = 4'b1111;
        #1;
        if (qaddr !== 4'b0001) begin
            err_count++;
            $display("FAIL reset_qaddr: got %b expected %b", qaddr, 4'b0001);
        end
        chk_count++;
        if (qvalid !== 1'b1) begin
            err_count++;
            $display("FAIL reset_qvalid: got %b expected %b", qvalid, 1'b1);
        end
        chk_count++;
        wen = 1'b1;
        waddr = 2'd0;
        tick();
        wen = 1'b0;
        if (qaddr !== 4'b0100) begin
            err_count++;
            $display("FAIL reset_then_touch0: got %b expected %b", qaddr, 4'b0100);
        end
        chk_count++;
        $display("test_reset done qaddr=%b", qaddr);
    endtask

    task automatic test_touch_sequence();
        do_reset();
        dvalid = 4'b1111;
        wen = 1'b1;
        waddr = 2'd0;
        tick();
        waddr = 2'd2;
        tick();
        wen = 1'b0;
        if (qaddr !== 4'b0010) begin
            err_count++;
            $display("FAIL touch_0_2: got %b expected %b", qaddr, 4'b0010);
        end
        chk_count++;
        $display("test_touch_sequence done qaddr=%b", qaddr);
    endtask

    task automatic test_masking();
        do_reset();
        dvalid = 4'b1110;
        #1;
        if (qaddr !== 4'b0010) begin
            err_count++;
            $display("FAIL mask_1110: got %b expected %b", qaddr, 4'b0010);
        end
        chk_count++;
        dvalid = 4'b0000;
        #1;
        if (qaddr !== 4'b0000 || qvalid !== 1'b0) begin
            err_count++;
            $display("FAIL mask_none: got qaddr=%b qvalid=%b expected qaddr=0000 qvalid=0", qaddr, qvalid);
        end
        chk_count++;
        alloc = 1'b1;
        tick();
        alloc = 1'b0;
        dvalid = 4'b1111;
        #1;
        if (qaddr !== 4'b0001) begin
            err_count++;
            $display("FAIL mask_alloc_ignored: got %b expected %b", qaddr, 4'b0001);
        end
        chk_count++;
        $display("test_masking done qaddr=%b", qaddr);
    endtask

    task automatic test_simultaneous();
        do_reset();
        dvalid = 4'b1111;
        alloc = 1'b1;
        wen = 1'b1;
        waddr = 2'd1;
        tick();
        idle_inputs();
        if (qaddr !== 4'b0100) begin
            err_count++;
            $display("FAIL simul_qaddr: got %b expected %b", qaddr, 4'b0100);
        end
        chk_count++;
        // Restricting to subjects 0/1 exposes node 1 (expected 0 -> subject 0).
        dvalid = 4'b0011;
        #1;
        if (qaddr !== 4'b0001) begin
            err_count++;
            $display("FAIL simul_node1: got %b expected %b", qaddr, 4'b0001);
        end
        chk_count++;
        dvalid = 4'b1111;
        $display("test_simultaneous done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        dvalid = 4'b1111;
        wen = 1'b1;
        waddr = 2'd0;
        tick();
        waddr = 2'd3;
        tick();
        reset = 1'b1;
        waddr = 2'd0;
        tick();
        idle_inputs();
        if (qaddr !== 4'b0001) begin
            err_count++;
            $display("FAIL reset_mid: got %b expected %b", qaddr, 4'b0001);
        end
        chk_count++;
        $display("test_reset_mid done qaddr=%b", qaddr);
    endtask

    task automatic test_alloc_sequence();
        logic [N-1:0] exp_seq [5];
        exp_seq = '{4'b0001, 4'b0100, 4'b0010, 4'b1000, 4'b0001};
        do_reset();
        dvalid = 4'b1111;
        alloc = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (qaddr !== exp_seq[i]) begin
                err_count++;
                $display("FAIL alloc_seq[%0d]: got %b expected %b", i, qaddr, exp_seq[i]);
            end
            chk_count++;
            $display("alloc step %0d qaddr=%b", i, qaddr);
            tick();
        end
        alloc = 1'b0;
    endtask

    task automatic test_random();
        logic [N-1:0] exp_q;
        do_reset();
        for (int i = 0; i < 120; i++) begin
            reset  = ($urandom_range(0, 31) == 0);
            wen    = $urandom_range(0, 1) == 1;
            alloc  = $urandom_range(0, 1) == 1;
            waddr  = L'($urandom_range(0, N - 1));
            dvalid = ($urandom_range(0, 3) == 0) ? 4'b1111 : N'($urandom_range(0, 15));
            #1;
            exp_q = m_pick(m_state, dvalid);
            if (qaddr !== exp_q || qvalid !== (exp_q != '0)) begin
                err_count++;
                $display("FAIL random[%0d]: got qaddr=%b qvalid=%b expected qaddr=%b qvalid=%b",
                         i, qaddr, qvalid, exp_q, exp_q != '0);
            end
            chk_count++;
            $display("txn %0d rst=%b wen=%b waddr=%0d alloc=%b dvalid=%b qaddr=%b",
                     i, reset, wen, waddr, alloc, dvalid, qaddr);
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        dvalid = '1;
        test_reset();
        test_touch_sequence();
        test_masking();
        test_simultaneous();
        test_reset_mid();
        test_alloc_sequence();
        test_random();
        $display("Result: errors=%0d of %0d checks", err_count, chk_count);
        $finish;
    end

endmodule

// File: doc/common_pseudo_lru_pick_binw.md
COMMON_PSEUDO_LRU_PICK_BINW -- requirements
Module: common_pseudo_lru_pick_binw

Interface
REQ-001 SHALL have parameter SUBJECT_COUNT_LOG2, default 1, giving log2 of subject count N (legal range 1..5).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1 bit, synchronous, active-high reset.
REQ-004 SHALL have port waddr, input, SUBJECT_COUNT_LOG2 bits, binary-encoded subject to touch.
REQ-005 SHALL have port wen, input, 1 bit, touch strobe for waddr.
REQ-006 SHALL have port alloc, input, 1 bit, consume the current pick and touch it.
REQ-007 SHALL have port dvalid, input, N bits, per-subject eligibility mask for picking.
REQ-008 SHALL have port qaddr, output, N bits, one-hot picked subject; all-zero when none eligible.
REQ-009 SHALL have port qvalid, output, 1 bit, high when qaddr holds exactly one set bit.

Function
REQ-010 SHALL hold tree pseudo-LRU state of N-1 node bits in heap order: root is node 0; node i has children 2i+1 (lower-index half) and 2i+2 (upper-index half).
REQ-011 Node bit 0 SHALL steer the pick toward the lower-index child; node bit 1 SHALL steer it toward the upper-index child.
REQ-012 Pick SHALL be combinational from state and dvalid: walk from root; at each node take the steered child unless that subtree has no eligible subject, in which case take the other child.
REQ-013 If dvalid is all-zero, SHALL drive qaddr all-zero and qvalid 0.
REQ-014 Touching subject s SHALL set every node on its path to point away from s: 1 if s is in the lower child, 0 if s is in the upper child. Nodes off the path are unchanged.
REQ-015 wen=1 SHALL decode waddr to one-hot internally and touch that subject at the next edge. Latency: the new pick is visible the cycle after the edge.
REQ-016 alloc=1 with qvalid=1 SHALL touch the subject currently on qaddr at the next edge.
REQ-017 alloc=1 with qvalid=0 SHALL be ignored, with no state change.
REQ-018 When wen and a qualified alloc occur in the same cycle, SHALL apply the alloc touch first and then the wen touch. Shared path nodes take the wen value. Both updates are applied in one edge.
REQ-019 A wen touch of an ineligible subject SHALL still update the state; dvalid affects picking only.
REQ-020 With N=2 the tree SHALL be the single root node; degenerate behaviour follows REQ-010..018 unchanged.

Reset
REQ-021 reset=1 SHALL clear all node bits to 0 at the next edge. With all subjects eligible, qaddr then equals one-hot subject 0 and qvalid is 1.
REQ-022 reset SHALL take priority over wen and alloc in the same cycle.
REQ-023 Outputs SHALL depend only on state and dvalid, so they reflect reset state in the cycle after reset.

Structure
REQ-024 SHALL place the derived constants (subject count, node count) in the team's shared common LRU package/header; the module defines no local copies.
REQ-025 SHALL instantiate one sub-module, macro_decoder_bin_onehot (binary to one-hot), for waddr decoding.
REQ-026 Pick and touch logic SHALL be generate-based over node index, with no per-N hand coding.

Verification (SUBJECT_COUNT_LOG2=2; nodes 0 root, 1 = {0,1}, 2 = {2,3})
REQ-027 SHALL check reset behaviour: reset, dvalid=1111 -> qaddr=0001, qvalid=1. Then wen, waddr=0 -> next cycle qaddr=0100.
REQ-028 SHALL check the touch sequence: from reset, touch 0 then touch 2 on successive cycles -> qaddr=0010 after the second edge.
REQ-029 SHALL check eligibility masking: reset state with dvalid=1110 -> qaddr=0010. With dvalid=0000 -> qaddr=0000, qvalid=0, and alloc=1 leaves the state unchanged.
REQ-030 SHALL check simultaneous events: reset state with alloc=1 (picks 0), wen=1, waddr=1 in the same cycle -> node0=1, node1=0; next qaddr=0100.
REQ-031 SHALL check reset mid-operation: touch 0 and 3 in successive cycles, then assert reset with wen=1 in the same cycle -> all nodes 0; next qaddr=0001.
REQ-032 SHALL check the allocation sequence: assert alloc continuously from reset with dvalid=1111 -> qaddr sequence 0001, 0100, 0010, 1000, 0001.
